// File: rtl/vscale_htif_tohost_poller_if.sv
// HTIF PCR request/response channel between the tohost poller (master) and the core's CSR port (slave).
interface vscale_htif_tohost_poller_if;
    logic        htif_pcr_req_valid;
    logic        htif_pcr_req_ready;
    logic        htif_pcr_req_rw;
    logic [11:0] htif_pcr_req_addr;
    logic [63:0] htif_pcr_req_data;
    logic        htif_pcr_resp_valid;
    logic        htif_pcr_resp_ready;
    logic [63:0] htif_pcr_resp_data;

    modport master (
        output htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
        output htif_pcr_resp_ready,
        input  htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data
    );

    modport slave (
        input  htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
        input  htif_pcr_resp_ready,
        output htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data
    );
endinterface

// File: rtl/vscale_htif_tohost_poller.sv
// Polls tohost until nonzero, clears it, then reports pass/exit code; requests hold until req_ready.
// Define VSCALE_HTIF_POLL_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog that ends polling with timeout=1.
module vscale_htif_tohost_poller #(
    parameter int          POLL_GAP    = 16,
    parameter logic [11:0] TOHOST_ADDR = 12'h780
`ifdef VSCALE_HTIF_POLL_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               stop,
    vscale_htif_tohost_poller_if.master        htif,
    output logic                               done,
    output logic                               pass,
    output logic [62:0]                        exit_code,
    output logic                               busy,
    output logic                               timeout
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GAP     = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_RESP = 3'd3;
    localparam logic [2:0] S_WR_REQ  = 3'd4;
    localparam logic [2:0] S_WR_RESP = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]  state, state_nxt;
    logic [7:0]  gap_cnt;
    logic [63:0] captured;
    logic        stop_pend;
    logic        req_fire, resp_fire, go, gap_last, tmo_hit, stop_any;

    assign req_fire  = htif.htif_pcr_req_valid && htif.htif_pcr_req_ready;
    assign resp_fire = htif.htif_pcr_resp_valid && htif.htif_pcr_resp_ready;
    assign go        = start && !stop;
    assign stop_any  = stop || stop_pend;
    assign gap_last  = (32'(gap_cnt) + 32'd1) >= 32'(POLL_GAP);
    assign htif.htif_pcr_req_data = 64'h0;

`ifdef VSCALE_HTIF_POLL_TIMEOUT_EN
    logic [31:0] to_cnt;
    assign tmo_hit = (to_cnt >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= 32'd0;
        end else if (go && (state == S_IDLE || state == S_DONE)) begin
            to_cnt <= 32'd0;
        end else if (busy && !tmo_hit) begin
            to_cnt <= to_cnt + 32'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (go) state_nxt = S_RD_REQ;
            S_DONE:    if (go) state_nxt = S_RD_REQ;
            S_GAP: begin
                if (stop)          state_nxt = S_IDLE;
                else if (tmo_hit)  state_nxt = S_DONE;
                else if (gap_last) state_nxt = S_RD_REQ;
            end
            // An accepted request is in flight, so a coincident stop is deferred to its response.
            S_RD_REQ: begin
                if (req_fire)     state_nxt = S_RD_RESP;
                else if (stop)    state_nxt = S_IDLE;
                else if (tmo_hit) state_nxt = S_DONE;
            end
            S_RD_RESP: begin
                if (resp_fire) begin
                    if (stop_any)                              state_nxt = S_IDLE;
                    else if (htif.htif_pcr_resp_data == 64'h0) state_nxt = S_GAP;
                    else                                       state_nxt = S_WR_REQ;
                end
            end
            S_WR_REQ:  if (req_fire) state_nxt = S_WR_RESP;
            S_WR_RESP: if (resp_fire) state_nxt = stop_any ? S_IDLE : S_DONE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                    <= S_IDLE;
            gap_cnt                  <= 8'd0;
            captured                 <= 64'h0;
            stop_pend                <= 1'b0;
            htif.htif_pcr_req_valid  <= 1'b0;
            htif.htif_pcr_req_rw     <= 1'b0;
            htif.htif_pcr_req_addr   <= 12'h0;
            htif.htif_pcr_resp_ready <= 1'b0;
            done                     <= 1'b0;
            pass                     <= 1'b0;
            exit_code                <= 63'h0;
            busy                     <= 1'b0;
            timeout                  <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
            if (state == S_RD_RESP && resp_fire)
                captured <= htif.htif_pcr_resp_data;
            if (state_nxt == S_IDLE || state_nxt == S_DONE)
                stop_pend <= 1'b0;
            else if (stop)
                stop_pend <= 1'b1;

            // Outputs are registered from the next state so none depends combinationally on inputs.
            htif.htif_pcr_req_valid  <= (state_nxt == S_RD_REQ) || (state_nxt == S_WR_REQ);
            htif.htif_pcr_req_rw     <= (state_nxt == S_WR_REQ);
            htif.htif_pcr_req_addr   <= ((state_nxt == S_RD_REQ) || (state_nxt == S_WR_REQ)) ?
                                        TOHOST_ADDR : 12'h0;
            htif.htif_pcr_resp_ready <= (state_nxt == S_RD_RESP) || (state_nxt == S_WR_RESP);
            busy                     <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            done                     <= (state_nxt == S_DONE);

            if (state_nxt == S_DONE) begin
                if (state == S_WR_RESP) begin
                    pass      <= (captured == 64'h1);
                    exit_code <= captured[63:1];
                    timeout   <= 1'b0;
                end else if (state != S_DONE) begin
                    pass      <= 1'b0;
                    exit_code <= 63'h0;
                    timeout   <= tmo_hit;
                end
            end else begin
                pass      <= 1'b0;
                exit_code <= 63'h0;
                timeout   <= 1'b0;
            end
        end
    end
endmodule
